// File: rtl/m_time_ctrl.sv
// Mode and adjustment controller for the clock counter chain: one-second tick in RUN,
// field select / adjust pulses with auto-repeat and display blink in the set states.
module m_time_ctrl #(
  parameter int unsigned TICK_DIV      = 50000000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_adj,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hour,
  output logic       clr_sec,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned PW    = $clog2(TICK_DIV);
  localparam int unsigned HALF  = TICK_DIV / 2;
  localparam int unsigned BW    = $clog2(HALF + 1);
  localparam int unsigned RMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW    = $clog2(RMAX + 1);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_HOUR = 2'd1;
  localparam logic [1:0] S_MIN  = 2'd2;
  localparam logic [1:0] S_SEC  = 2'd3;

  logic          r_mode_s1, r_mode_s2, r_mode_prev, r_mode_ev;
  logic          r_adj_s1, r_adj_s2, r_adj_prev, r_adj_ev;
  logic          w_mode_rise, w_adj_rise;

  logic [1:0]    r_state, w_state_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [BW-1:0] r_blink_cnt, w_blink_cnt_nxt;
  logic          r_blink, w_blink_nxt;
  logic [RW-1:0] r_rep_cnt, w_rep_cnt_nxt;
  logic          r_rep_act, w_rep_act_nxt;
  logic          r_inc_sec, r_inc_min, r_inc_hour, r_clr_sec;
  logic          w_inc_sec, w_inc_min, w_inc_hour, w_clr_sec;

  // Synchronizers reset to 1 so a button held through reset must be released before it counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_s1   <= 1'b1;
      r_mode_s2   <= 1'b1;
      r_mode_prev <= 1'b1;
      r_mode_ev   <= 1'b0;
      r_adj_s1    <= 1'b1;
      r_adj_s2    <= 1'b1;
      r_adj_prev  <= 1'b1;
      r_adj_ev    <= 1'b0;
    end else begin
      r_mode_s1   <= btn_mode;
      r_mode_s2   <= r_mode_s1;
      r_mode_prev <= r_mode_s2;
      r_mode_ev   <= w_mode_rise;
      r_adj_s1    <= btn_adj;
      r_adj_s2    <= r_adj_s1;
      r_adj_prev  <= r_adj_s2;
      r_adj_ev    <= w_adj_rise;
    end
  end

  assign w_mode_rise = r_mode_s2 & ~r_mode_prev;
  assign w_adj_rise  = r_adj_s2 & ~r_adj_prev;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_presc     <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
      r_rep_cnt   <= '0;
      r_rep_act   <= 1'b0;
      r_inc_sec   <= 1'b0;
      r_inc_min   <= 1'b0;
      r_inc_hour  <= 1'b0;
      r_clr_sec   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_presc     <= w_presc_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_blink     <= w_blink_nxt;
      r_rep_cnt   <= w_rep_cnt_nxt;
      r_rep_act   <= w_rep_act_nxt;
      r_inc_sec   <= w_inc_sec;
      r_inc_min   <= w_inc_min;
      r_inc_hour  <= w_inc_hour;
      r_clr_sec   <= w_clr_sec;
    end
  end

  // Next state and next outputs; a mode event overrides any adjust activity
  always_comb begin
    w_state_nxt     = r_state;
    w_presc_nxt     = '0;
    w_blink_cnt_nxt = r_blink_cnt;
    w_blink_nxt     = r_blink;
    w_rep_cnt_nxt   = r_rep_cnt;
    w_rep_act_nxt   = r_rep_act;
    w_inc_sec       = 1'b0;
    w_inc_min       = 1'b0;
    w_inc_hour      = 1'b0;
    w_clr_sec       = 1'b0;

    if (r_mode_ev) begin
      case (r_state)
        S_RUN:   w_state_nxt = S_HOUR;
        S_HOUR:  w_state_nxt = S_MIN;
        S_MIN:   w_state_nxt = S_SEC;
        default: w_state_nxt = S_RUN;
      endcase
      w_blink_cnt_nxt = '0;
      w_blink_nxt     = 1'b0;
      w_rep_cnt_nxt   = '0;
      w_rep_act_nxt   = 1'b0;
    end else if (r_state == S_RUN) begin
      w_blink_cnt_nxt = '0;
      w_blink_nxt     = 1'b0;
      w_rep_cnt_nxt   = '0;
      w_rep_act_nxt   = 1'b0;
      if (r_presc == PW'(TICK_DIV - 1)) begin
        w_inc_sec = 1'b1;
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
    end else begin
      if (r_blink_cnt == BW'(HALF - 1)) begin
        w_blink_cnt_nxt = '0;
        w_blink_nxt     = ~r_blink;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + BW'(1);
      end

      if (r_adj_ev) begin
        case (r_state)
          S_HOUR:  w_inc_hour = 1'b1;
          S_MIN:   w_inc_min  = 1'b1;
          default: w_clr_sec  = 1'b1;
        endcase
        if (r_state != S_SEC) begin
          w_rep_act_nxt = 1'b1;
          w_rep_cnt_nxt = RW'(REPEAT_DELAY - 1);
        end
      end else if (r_rep_act) begin
        if (!r_adj_s2) begin
          w_rep_act_nxt = 1'b0;
        end else if (r_rep_cnt == '0) begin
          w_inc_hour    = (r_state == S_HOUR);
          w_inc_min     = (r_state == S_MIN);
          w_rep_cnt_nxt = RW'(REPEAT_PERIOD - 1);
        end else begin
          w_rep_cnt_nxt = r_rep_cnt - RW'(1);
        end
      end
    end
  end

  assign inc_sec  = r_inc_sec;
  assign inc_min  = r_inc_min;
  assign inc_hour = r_inc_hour;
  assign clr_sec  = r_clr_sec;
  assign mode     = r_state;
  assign blink    = r_blink;

endmodule

// File: tb/tb_m_time_ctrl.sv
// Scoreboard bench for m_time_ctrl: expected pulse cycles are queued when stimulus is
// driven and matched against pulses seen on the outputs.
module tb_m_time_ctrl;

  localparam logic [3:0] K_SEC  = 4'b0001;
  localparam logic [3:0] K_MIN  = 4'b0010;
  localparam logic [3:0] K_HOUR = 4'b0100;
  localparam logic [3:0] K_CLR  = 4'b1000;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  kind;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_adj;
  logic       inc_sec, inc_min, inc_hour, clr_sec;
  logic [1:0] mode;
  logic       blink;

  int unsigned cyc;
  int          n_checks;
  int          n_errors;
  exp_t        sb[$];

  m_time_ctrl #(
    .TICK_DIV      (10),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (5)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_mode (btn_mode),
    .btn_adj  (btn_adj),
    .inc_sec  (inc_sec),
    .inc_min  (inc_min),
    .inc_hour (inc_hour),
    .clr_sec  (clr_sec),
    .mode     (mode),
    .blink    (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic push(input int unsigned t, input logic [3:0] k);
    exp_t e;
    e.cyc  = t;
    e.kind = k;
    sb.push_back(e);
  endtask

  // One mode press: mode must still be old 3 edges after the press edge and new after 4
  task automatic press_mode(input logic [1:0] old_m, input logic [1:0] new_m);
    int unsigned c;
    c = cyc;
    btn_mode = 1'b1;
    wait_cyc(c + 3);
    check("mode_before", 32'(mode), 32'(old_m));
    wait_cyc(c + 4);
    check("mode_after", 32'(mode), 32'(new_m));
    btn_mode = 1'b0;
    wait_cyc(c + 8);
  endtask

  // Pulse monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin
    logic [3:0] k;
    k = {clr_sec, inc_hour, inc_min, inc_sec};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      check("missed_pulse", 32'(0), 32'(sb[0].kind));
      void'(sb.pop_front());
    end
    if (k != 4'b0000) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(k), 32'(0));
      end else begin
        check("pulse_cycle", cyc, sb[0].cyc);
        check("pulse_kind", 32'(k), 32'(sb[0].kind));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int unsigned c0, c, e;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    btn_mode = 1'b0;
    btn_adj  = 1'b0;

    // Reset and run
    wait_cyc(3);
    check("rst_mode", 32'(mode), 32'(0));
    check("rst_blink", 32'(blink), 32'(0));
    check("rst_pulses", 32'({clr_sec, inc_hour, inc_min, inc_sec}), 32'(0));
    c0 = cyc;
    rst_n = 1'b1;
    push(c0 + 10, K_SEC);
    push(c0 + 20, K_SEC);
    push(c0 + 30, K_SEC);
    for (int i = 1; i <= 35; i++) begin
      wait_cyc(c0 + i);
      if (i % 7 == 0) begin
        check("run_mode", 32'(mode), 32'(0));
        check("run_blink", 32'(blink), 32'(0));
      end
    end

    // Mode cycling
    press_mode(2'd0, 2'd1);
    press_mode(2'd1, 2'd2);
    press_mode(2'd2, 2'd3);
    c = cyc;
    press_mode(2'd3, 2'd0);
    e = c + 4;
    push(e + 10, K_SEC);
    push(e + 20, K_SEC);
    wait_cyc(e + 21);
    press_mode(2'd0, 2'd1);

    // SET_HOUR adjust with auto-repeat
    c = cyc;
    btn_adj = 1'b1;
    push(c + 4, K_HOUR);
    push(c + 24, K_HOUR);
    push(c + 29, K_HOUR);
    push(c + 34, K_HOUR);
    push(c + 39, K_HOUR);
    wait_cyc(c + 40);
    btn_adj = 1'b0;
    wait_cyc(c + 50);

    // SET_SEC: single clear, blink phase
    press_mode(2'd1, 2'd2);
    c = cyc;
    press_mode(2'd2, 2'd3);
    e = c + 4;
    c = cyc;
    btn_adj = 1'b1;
    push(c + 4, K_CLR);
    for (int i = 1; i <= 45; i++) begin
      wait_cyc(c + i);
      if (i == 40) btn_adj = 1'b0;
      check("blink_sec", 32'(blink), 32'(((cyc - e) / 5) % 2));
    end
    wait_cyc(c + 48);

    // Back to RUN, then SET_HOUR, then collision
    c = cyc;
    press_mode(2'd3, 2'd0);
    e = c + 4;
    push(e + 10, K_SEC);
    wait_cyc(e + 11);
    press_mode(2'd0, 2'd1);
    c = cyc;
    btn_mode = 1'b1;
    btn_adj  = 1'b1;
    wait_cyc(c + 3);
    check("coll_mode_before", 32'(mode), 32'(1));
    wait_cyc(c + 4);
    check("coll_mode_after", 32'(mode), 32'(2));
    btn_mode = 1'b0;
    wait_cyc(c + 40);
    btn_adj = 1'b0;
    wait_cyc(c + 46);

    // Reset during a SET_MIN repeat burst
    c = cyc;
    btn_adj = 1'b1;
    push(c + 4, K_MIN);
    push(c + 24, K_MIN);
    push(c + 29, K_MIN);
    wait_cyc(c + 29);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pulses", 32'({clr_sec, inc_hour, inc_min, inc_sec}), 32'(0));
    check("arst_mode", 32'(mode), 32'(0));
    check("arst_blink", 32'(blink), 32'(0));
    wait_cyc(c + 32);
    c0 = cyc;
    rst_n = 1'b1;
    push(c0 + 10, K_SEC);
    push(c0 + 20, K_SEC);
    for (int i = 1; i <= 25; i++) begin
      wait_cyc(c0 + i);
      if (i % 5 == 0) check("post_rst_mode", 32'(mode), 32'(0));
    end
    btn_adj = 1'b0;
    wait_cyc(c0 + 28);
    check("sb_empty", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/m_time_ctrl.md
# m_time_ctrl

Mode and adjustment controller for the stopwatch/clock counter chain. It divides the system clock into a one-second increment pulse for the seconds counter in run mode. It also provides a set-time mode, in which two pushbuttons step through the hour, minute and second fields and adjust the selected one. Outputs are single-cycle enable pulses consumed by the second/minute/hour counters, plus a field select and a blink flag for the display driver.

## Interface
- TICK_DIV, 50000000: clock cycles per second tick (≥4, even).
- REPEAT_DELAY, 25000000: cycles btn_adj must stay held after the first adjust pulse before auto-repeat begins (≥1).
- REPEAT_PERIOD, 5000000: cycles between auto-repeat pulses (≥1).
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_mode  in  1  mode button, already debounced, asynchronous to clk.
- btn_adj  in  1  adjust button, already debounced, asynchronous to clk.
- inc_sec  out  1  one-cycle enable: advance seconds counter (carry chain propagates).
- inc_min  out  1  one-cycle enable: advance minute field only, no carry out.
- inc_hour  out  1  one-cycle enable: advance hour field only, wraps 23→00, no carry out.
- clr_sec  out  1  one-cycle enable: clear seconds to 00.
- mode  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC.
- blink  out  1  display blank phase for the selected field.

## Operation
- Reset: state RUN; prescaler, blink counter and repeat counter at 0. All outputs are 0 (mode=0, blink=0, all pulses 0).
- Button path: each button goes through a 2-FF synchronizer and then an edge register. A rise is a one-cycle event: sync2 & ~prev.
- FSM, advanced only on a btn_mode rise: RUN→SET_HOUR→SET_MIN→SET_SEC→RUN. mode is the registered state encoding.
- RUN
  - Prescaler counts 0..TICK_DIV-1. On the cycle it wraps, inc_sec=1 for one cycle.
  - btn_adj is ignored.
  - blink=0.
- Set states
  - Prescaler is held at 0, so time is frozen and inc_sec=0.
  - Each btn_adj rise produces one pulse: SET_HOUR→inc_hour, SET_MIN→inc_min, SET_SEC→clr_sec.
  - Auto-repeat applies in SET_HOUR and SET_MIN only. With btn_adj still held, a further pulse fires REPEAT_DELAY cycles after the first pulse, then every REPEAT_PERIOD cycles until release.
  - SET_SEC never repeats.
- Blink: in set states, blink toggles every TICK_DIV/2 cycles, starting at 0 on state entry. Forced to 0 in RUN.
- Simultaneous btn_mode and btn_adj rises in the same cycle: the mode change wins, and the adjust event is discarded (no pulse).
- Any state change clears the repeat counter and the blink counter. A held btn_adj therefore does not repeat into the new field until it is released and pressed again.
- Exiting SET_SEC to RUN: prescaler restarts at 0. The first inc_sec occurs TICK_DIV cycles after the transition.
- At most one of inc_sec/inc_min/inc_hour/clr_sec is high in any cycle.
- rst_n asserted mid-operation forces reset values immediately (asynchronously), including any pulse in progress. After rst_n deasserts, a button already held is not treated as a rise until sync2 has seen 0.

## Timing
- Button latency:
  - Button high before posedge N and low before posedge N-1.
  - Sync2 is high after posedge N+1, and the rise is detected in the following cycle.
  - The registered output pulse (or mode change) is visible after posedge N+3 and lasts exactly 1 cycle.
- Repeat: first pulse at edge P; repeats at P+REPEAT_DELAY, then P+REPEAT_DELAY+k·REPEAT_PERIOD.
- Release: btn_adj low before posedge R stops repeats. No pulse can occur after posedge R+2.
- RUN tick: with the FSM entering RUN at edge T, inc_sec is high after edges T+TICK_DIV, T+2·TICK_DIV, …
- All outputs are registered, with no combinational input→output paths.

## Test plan
- Reset and run:
  - Overrides: TICK_DIV=10, REPEAT_DELAY=20, REPEAT_PERIOD=5.
  - Release rst_n and hold buttons low for 35 cycles.
  - Required: mode=0, blink=0, and inc_sec pulses at cycles 10, 20, 30 after release, each 1 cycle wide.
- Mode cycling: four btn_mode presses give mode 1,2,3,0, each change 3 edges after its press. inc_sec stops in modes 1–3, and the first inc_sec after returning to 0 comes 10 cycles later.
- Adjust with repeat:
  - In SET_HOUR, hold btn_adj for 40 cycles.
  - Required: inc_hour at press+3, +23, +28, +33, +38 (and +43 if still within release+2). inc_min/inc_sec/clr_sec stay 0.
- SET_SEC: hold btn_adj for 40 cycles. Required: exactly one clr_sec and no repeats. blink toggles every 5 cycles starting at 0.
- Collision: btn_mode and btn_adj rise in the same cycle in SET_HOUR. Required: mode→2 and no inc_hour or inc_min pulse. Holding btn_adj afterwards produces no repeat pulses.
- Reset mid-repeat: assert rst_n low during an auto-repeat burst in SET_MIN. Required: all outputs are 0 immediately. After release with btn_adj still held, no inc_min pulse appears and mode=0.
